// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcode encodings, forwarding
// selects, port widths and the multi-cycle FSM state enum.
package ex_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int ALU_OP_WIDTH  = 5;
  localparam int FORWARD_WIDTH = 2;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_NOP    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_AND    = 5'd3,
    ALU_OR     = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SLL    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_SLT    = 5'd9,
    ALU_SLTU   = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [FORWARD_WIDTH-1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_DIV_RUN,
    ST_DONE
  } md_state_e;

  // Ops that go through the iterative unit.
  function automatic logic is_muldiv(input logic [ALU_OP_WIDTH-1:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_div(input logic [ALU_OP_WIDTH-1:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_md_muldiv_iter.sv
// Iterative multiply/divide datapath, one bit per step.
//   start  : load operands (magnitudes), sign flags and special-case flags
//   step   : advance one iteration; last is high on the final step
//   res    : fixed-up result of the final step (valid together with last)
// acc holds {high, low} of the product for MUL*, {remainder, quotient}
// for DIV*/REM*.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    start,
  input  logic                    step,
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]         a,
  input  logic [XLEN-1:0]         b,
  output logic                    last,
  output logic [XLEN-1:0]         res
);

  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN-1:0]   dvs, a_orig;
  logic [SHW-1:0]    cnt;
  logic              div_q, sel_hi_q, neg_q, neg_r, div0_q, ovf_q;

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, rr, rd;
  logic              ge;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    sgn_a = ((op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
             (op == ALU_DIV) || (op == ALU_REM)) && a[XLEN-1];
    sgn_b = ((op == ALU_MUL) || (op == ALU_MULH) ||
             (op == ALU_DIV) || (op == ALU_REM)) && b[XLEN-1];
    mag_a = sgn_a ? -a : a;
    mag_b = sgn_b ? -b : b;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
    rr      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge      = (rr >= {1'b0, dvs});
    rd      = ge ? (rr - {1'b0, dvs}) : rr;
    if (div_q) acc_nxt = {rd[XLEN-1:0], acc[XLEN-2:0], ge};
    else       acc_nxt = {mul_sum, acc[XLEN-1:1]};
  end

  // Sign fix-up and special cases applied to the final iteration's value.
  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem  = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (div0_q) begin
      quo = '1;
      rem = a_orig;
    end
    if (ovf_q) begin
      quo = a_orig;
      rem = '0;
    end
    if (div_q) res = sel_hi_q ? rem : quo;
    else       res = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign last = (cnt == SHW'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      dvs      <= '0;
      a_orig   <= '0;
      cnt      <= '0;
      div_q    <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start) begin
      div_q    <= is_div(op);
      sel_hi_q <= (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU) ||
                  (op == ALU_REM)  || (op == ALU_REMU);
      neg_q    <= sgn_a ^ sgn_b;
      neg_r    <= sgn_a;
      div0_q   <= is_div(op) && (b == '0);
      ovf_q    <= ((op == ALU_DIV) || (op == ALU_REM)) &&
                  (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      a_orig   <= a;
      cnt      <= '0;
      if (is_div(op)) begin
        acc <= {{XLEN{1'b0}}, mag_a};
        dvs <= mag_b;
      end else begin
        acc <= {{XLEN{1'b0}}, mag_b};
        dvs <= mag_a;
      end
    end else if (step) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ex_md.sv
// Execute stage with operand forwarding, single-cycle base ALU and an
// iterative multiply/divide unit.
//   flush            : abort in-flight op, drop any pending result
//   in_valid         : op present (accepted in IDLE/DONE only)
//   rs1/rs2/imm      : operands; forward_op1/2 select MEM > WB > register
//   alu_op, alu_src  : operation, op2 = imm when alu_src
//   busy             : mul/div iterating, upstream must stall
//   out_valid        : alu_res / bypass_op2 valid this cycle
module ex_md
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  input  logic [XLEN-1:0]          imm,
  input  logic [FORWARD_WIDTH-1:0] forward_op1,
  input  logic [FORWARD_WIDTH-1:0] forward_op2,
  input  logic [XLEN-1:0]          forward_data_mem,
  input  logic [XLEN-1:0]          forward_data_wb,
  input  logic [ALU_OP_WIDTH-1:0]  alu_op,
  input  logic                     alu_src,
  output logic                     busy,
  output logic                     out_valid,
  output logic [XLEN-1:0]          alu_res,
  output logic [XLEN-1:0]          bypass_op2
);

  md_state_e       state_q, state_d;
  logic [XLEN-1:0] op1, rs2f, op2, base_res, md_res;
  logic            accept, md_op, md_last;

  // Forwarding: MEM is younger than WB, so it wins.
  always_comb begin
    case (forward_op1)
      FWD_MEM: op1 = forward_data_mem;
      FWD_WB:  op1 = forward_data_wb;
      default: op1 = rs1_data;
    endcase
    case (forward_op2)
      FWD_MEM: rs2f = forward_data_mem;
      FWD_WB:  rs2f = forward_data_wb;
      default: rs2f = rs2_data;
    endcase
    op2 = alu_src ? imm : rs2f;
  end

  always_comb begin
    base_res = '0;
    case (alu_op)
      ALU_ADD:  base_res = op1 + op2;
      ALU_SUB:  base_res = op1 - op2;
      ALU_AND:  base_res = op1 & op2;
      ALU_OR:   base_res = op1 | op2;
      ALU_XOR:  base_res = op1 ^ op2;
      ALU_SLL:  base_res = op1 << op2[SHW-1:0];
      ALU_SRL:  base_res = op1 >> op2[SHW-1:0];
      ALU_SRA:  base_res = $signed(op1) >>> op2[SHW-1:0];
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      default:  base_res = '0;
    endcase
  end

  assign busy   = (state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN);
  assign md_op  = is_muldiv(alu_op);
  assign accept = in_valid && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  muldiv_iter #(.XLEN(XLEN), .SHW(SHW)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .start (accept && md_op),
    .step  (busy),
    .op    (alu_op),
    .a     (op1),
    .b     (op2),
    .last  (md_last),
    .res   (md_res)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept && md_op) state_d = is_div(alu_op) ? ST_DIV_RUN : ST_MUL_RUN;
        else                 state_d = ST_IDLE;
      end
      ST_MUL_RUN, ST_DIV_RUN: if (md_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      out_valid  <= 1'b0;
      alu_res    <= '0;
      bypass_op2 <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      if (accept) begin
        bypass_op2 <= rs2f;
        if (!md_op) begin
          alu_res   <= base_res;
          out_valid <= 1'b1;
        end
      end else if (!flush && busy && md_last) begin
        alu_res   <= md_res;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_md.sv
module tb_ex_md;
  import ex_pkg::*;

  localparam int XLEN = 32;

  logic                     clk = 1'b0;
  logic                     rst_n, flush, in_valid, alu_src;
  logic [XLEN-1:0]          rs1_data, rs2_data, imm, forward_data_mem, forward_data_wb;
  logic [FORWARD_WIDTH-1:0] forward_op1, forward_op2;
  logic [ALU_OP_WIDTH-1:0]  alu_op;
  logic                     busy, out_valid;
  logic [XLEN-1:0]          alu_res, bypass_op2;

  int checks = 0;
  int errors = 0;

  ex_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .forward_op1(forward_op1), .forward_op2(forward_op2),
    .forward_data_mem(forward_data_mem), .forward_data_wb(forward_data_wb),
    .alu_op(alu_op), .alu_src(alu_src),
    .busy(busy), .out_valid(out_valid), .alu_res(alu_res), .bypass_op2(bypass_op2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: results straight from the arithmetic definition of each op.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    p  = '0;
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SLL:    return a << b[4:0];
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return sa >>> b[4:0];
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      ALU_MUL, ALU_MULH: begin
        p = $signed({{34{a[31]}}, a}) * $signed({{34{b[31]}}, b});
        return (op == ALU_MUL) ? p[31:0] : p[63:32];
      end
      ALU_MULHSU: begin
        p = $signed({{34{a[31]}}, a}) * $signed({34'd0, b});
        return p[63:32];
      end
      ALU_MULHU: begin
        p = $signed({34'd0, a}) * $signed({34'd0, b});
        return p[63:32];
      end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      ALU_REMU:   return (b == 0) ? a : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op      = op;
    rs1_data    = a;
    rs2_data    = b;
    forward_op1 = FWD_NONE;
    forward_op2 = FWD_NONE;
    alu_src     = 1'b0;
    imm         = '0;
    in_valid    = 1'b1;
  endtask

  // Issue a mul/div op and wait for it to leave the busy phase.
  task automatic exec_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic vld);
    drive(op, a, b);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (busy === 1'b1 && lat < 100) begin
      lat++;
      tick();
    end
    vld = out_valid;
    res = alu_res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_src = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; forward_data_mem = '0; forward_data_wb = '0;
    forward_op1 = FWD_NONE; forward_op2 = FWD_NONE; alu_op = ALU_NOP;
    #22;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (alu_res !== 32'd0)  begin errors++; $display("FAIL reset_alu_res got %h want 0", alu_res); end
    checks++; if (bypass_op2 !== 32'd0) begin errors++; $display("FAIL reset_bypass got %h want 0", bypass_op2); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    drive(ALU_ADD, 32'd99, 32'd7);
    forward_op1 = FWD_MEM; forward_data_mem = 32'd5; forward_data_wb = 32'd1000;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_mem_valid got %0b want 1", out_valid); end
    checks++; if (alu_res !== 32'd12) begin errors++; $display("FAIL fwd_mem_res got %0d want 12", alu_res); end
    checks++; if (bypass_op2 !== 32'd7) begin errors++; $display("FAIL fwd_mem_bypass got %0d want 7", bypass_op2); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_idle_valid got %0b want 0", out_valid); end

    drive(ALU_SUB, 32'd1, 32'd3);
    forward_op1 = FWD_WB; forward_data_wb = 32'd50;
    forward_op2 = FWD_MEM; forward_data_mem = 32'd8;
    tick();
    in_valid = 1'b0;
    checks++; if (alu_res !== 32'd42) begin errors++; $display("FAIL fwd_wb_res got %0d want 42", alu_res); end
    checks++; if (bypass_op2 !== 32'd8) begin errors++; $display("FAIL fwd_wb_bypass got %0d want 8", bypass_op2); end

    drive(ALU_ADD, 32'd10, 32'd3);
    forward_op2 = FWD_WB; forward_data_wb = 32'd20; imm = 32'd100; alu_src = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (alu_res !== 32'd110) begin errors++; $display("FAIL imm_res got %0d want 110", alu_res); end
    checks++; if (bypass_op2 !== 32'd20) begin errors++; $display("FAIL imm_bypass got %0d want 20", bypass_op2); end
    tick();
  endtask

  task automatic test_shift_cmp();
    logic [4:0]  ops [3] = '{ALU_SRA, ALU_SLT, ALU_SLTU};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'd31, 32'd1, 32'd1};
    logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], as[i], bs[i]);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || alu_res !== exp[i]) begin
        errors++; $display("FAIL shift_cmp_%0d got v=%0b %h want v=1 %h", i, out_valid, alu_res, exp[i]);
      end
    end
    tick();
  endtask

  // Back-to-back base ops with random forwarding; one result per cycle.
  task automatic test_base_random();
    logic [31:0] exp_res, exp_byp, o1, r2, o2;
    logic [4:0]  op;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 10));
      drive(op, rand_operand(), rand_operand());
      forward_op1 = 2'($urandom_range(0, 2));
      forward_op2 = 2'($urandom_range(0, 2));
      forward_data_mem = rand_operand();
      forward_data_wb  = rand_operand();
      imm     = rand_operand();
      alu_src = 1'($urandom_range(0, 1));
      o1 = (forward_op1 == FWD_MEM) ? forward_data_mem : (forward_op1 == FWD_WB) ? forward_data_wb : rs1_data;
      r2 = (forward_op2 == FWD_MEM) ? forward_data_mem : (forward_op2 == FWD_WB) ? forward_data_wb : rs2_data;
      o2 = alu_src ? imm : r2;
      exp_res = model(op, o1, o2);
      exp_byp = r2;
      tick();
      checks++;
      if (out_valid !== 1'b1 || alu_res !== exp_res || bypass_op2 !== exp_byp) begin
        errors++;
        $display("FAIL base_rand op=%0d a=%h b=%h got v=%0b res=%h byp=%h want v=1 res=%h byp=%h",
                 op, o1, o2, out_valid, alu_res, bypass_op2, exp_res, exp_byp);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_muldiv();
    logic [4:0]  ops [5] = '{ALU_MULH, ALU_MUL, ALU_DIV, ALU_REM, ALU_DIVU};
    logic [31:0] as  [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'd7, 32'd7};
    logic [31:0] bs  [5] = '{32'd3, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] res, a, b, e;
    logic [4:0]  op;
    logic        vld;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      exec_md(ops[i], as[i], bs[i], res, lat, vld);
      checks++;
      if (lat != 32 || vld !== 1'b1 || res !== exp[i] || busy !== 1'b0) begin
        errors++; $display("FAIL md_dir_%0d got lat=%0d v=%0b res=%h want lat=32 v=1 res=%h", i, lat, vld, res, exp[i]);
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL md_dir_after_%0d got v=%0b want 0", i, out_valid); end
    end
    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(11, 18));
      a  = rand_operand();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_operand();
      e  = model(op, a, b);
      exec_md(op, a, b, res, lat, vld);
      checks++;
      if (lat != 32 || vld !== 1'b1 || res !== e) begin
        errors++; $display("FAIL md_rand op=%0d a=%h b=%h got lat=%0d v=%0b res=%h want lat=32 v=1 res=%h",
                           op, a, b, lat, vld, res, e);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    drive(ALU_DIV, 32'd1000, 32'd7);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_next got busy=%0b v=%0b want 0 0", busy, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got out_valid seen=1 want 0"); end
    drive(ALU_ADD, 32'd3, 32'd4);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || alu_res !== 32'd7) begin
      errors++; $display("FAIL flush_then_add got v=%0b res=%0d want v=1 7", out_valid, alu_res);
    end
    drive(ALU_MUL, 32'd3, 32'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_priority got busy=%0b v=%0b want 0 0", busy, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd2);
    tick();
    checks++; if (alu_res !== 32'd3) begin errors++; $display("FAIL pre_reset_add got %0d want 3", alu_res); end
    drive(ALU_MUL, 32'd12345, 32'd678);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || alu_res !== 32'd0 || bypass_op2 !== 32'd0) begin
      errors++; $display("FAIL reset_mid got busy=%0b v=%0b res=%h byp=%h want all 0", busy, out_valid, alu_res, bypass_op2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid | busy;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_quiet got activity=1 want 0"); end
  endtask

  // DIV with in_valid held high: ignored while busy, accepted in DONE.
  task automatic test_back_to_back();
    logic [31:0] e;
    int lat = 0;
    e = model(ALU_DIV, -32'sd100, 32'd7);
    drive(ALU_DIV, -32'sd100, 32'd7);
    tick();
    drive(ALU_ADD, 32'd20, 32'd22);
    while (busy === 1'b1 && lat < 100) begin
      lat++;
      tick();
    end
    checks++;
    if (lat != 32 || out_valid !== 1'b1 || alu_res !== e) begin
      errors++; $display("FAIL b2b_div got lat=%0d v=%0b res=%h want lat=32 v=1 res=%h", lat, out_valid, alu_res, e);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_res !== 32'd42 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_add got v=%0b res=%0d busy=%0b want v=1 42 busy=0", out_valid, alu_res, busy);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_after got v=%0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_shift_cmp();
    test_base_random();
    test_muldiv();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
